// File: rtl/matrix_result_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// matrix_result_reader
//
// Reads ELEMS 32-bit words (a 3x3 matrix by default) out of a register file
// and streams them to a consumer over a valid/ready handshake. It also keeps
// a running modulo-2^32 checksum of the elements the consumer accepted.
// Each element takes one LOAD cycle, which reads the register file, followed
// by one or more SEND cycles, which offer the element until it is accepted.
//
// Optional feature:
//   MATRIX_READER_TRANSPOSE_EN - when defined, the register file is read
//   column-major, so a transposed matrix is streamed. out_idx still counts
//   0..ELEMS-1 in order. When undefined, reads are row-major (addr = idx).
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high reset
//   start      one-cycle readout request, honoured only when idle
//   sel        register-file element select (non-zero only during LOAD)
//   data_RW    register-file direction: 1 = write/reader inactive, 0 = read
//   rd_data    register-file word at sel, valid combinationally
//   out_data   streamed element
//   out_idx    index of out_data within the transfer
//   out_valid  out_data/out_idx valid
//   out_ready  consumer accepts when out_valid && out_ready
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last element is accepted
//   checksum   running sum of accepted elements, modulo 2^32
// -----------------------------------------------------------------------------
module matrix_result_reader #(
   parameter int ELEMS = 9,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [IDX_W-1:0] sel,
   output logic             data_RW,
   input  logic [31:0]      rd_data,
   output logic [31:0]      out_data,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic [31:0]      checksum
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;

   // Register-file address for a given element index.
   function automatic logic [IDX_W-1:0] addr_of(input logic [IDX_W-1:0] i);
`ifdef MATRIX_READER_TRANSPOSE_EN
      addr_of = IDX_W'(3 * (32'(i) % 3) + 32'(i) / 3);
`else
      addr_of = i;
`endif
   endfunction

   // These are pure decodes of the state register, so they never glitch
   // relative to the registered outputs and come out of reset correct.
   assign busy    = (state != IDLE);
   assign data_RW = (state == IDLE);
   assign sel     = (state == LOAD) ? addr_of(idx) : '0;

   // NOTE: every register in this block uses non-blocking assignments so that
   // all right-hand sides see pre-edge values, whatever the statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         out_data  <= '0;
         out_idx   <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         checksum  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  idx      <= '0;
                  checksum <= '0;
                  state    <= LOAD;
               end
            end

            LOAD: begin
               out_data  <= rd_data;
               out_idx   <= idx;
               out_valid <= 1'b1;
               state     <= SEND;
            end

            SEND: begin
               // out_data/out_idx are held until the consumer takes them.
               if (out_ready) begin
                  checksum  <= checksum + out_data;
                  out_valid <= 1'b0;
                  if (idx == LAST_IDX) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= LOAD;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_result_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_matrix_result_reader
//
// Directed bench for matrix_result_reader. A small register-file model feeds
// rd_data from sel. Each transfer pushes its expected elements into a queue,
// and every accepted handshake pops one entry and compares it. The bench
// honours MATRIX_READER_TRANSPOSE_EN when computing expected read order.
// -----------------------------------------------------------------------------
module tb_matrix_result_reader;

   localparam int ELEMS = 9;
   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [IDX_W-1:0] sel;
   logic             data_RW;
   logic [31:0]      rd_data;
   logic [31:0]      out_data;
   logic [IDX_W-1:0] out_idx;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic [31:0]      checksum;

   logic [31:0] mem [16];

   typedef struct {
      logic [31:0]      data;
      logic [IDX_W-1:0] idx;
   } item_t;

   item_t       sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc;
   int          n_pop;
   int          n_done;
   int          load_idx;
   int          done_cyc;
   logic [31:0] model_cs;

   matrix_result_reader #(.ELEMS(ELEMS), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sel       (sel),
      .data_RW   (data_RW),
      .rd_data   (rd_data),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .checksum  (checksum)
   );

   assign rd_data = mem[sel];

   always #5 clk = ~clk;

   function automatic int addr_model(input int i);
`ifdef MATRIX_READER_TRANSPOSE_EN
      return 3 * (i % 3) + i / 3;
`else
      return i;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Handshake decided by the values stable before the edge, then advance.
   task automatic tick();
      item_t e;
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) e = '{32'hDEADBEEF, '1};
         else                e = sb.pop_front();
         check("elem_data", out_data, e.data);
         check("elem_idx", 32'(out_idx), 32'(e.idx));
         model_cs += e.data;
         n_pop++;
         load_idx = n_pop;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
         n_done++;
         if (done_cyc < 0) done_cyc = cyc;
      end
      // LOAD is the only busy state with neither out_valid nor done high.
      if (!reset && busy && !out_valid && !done) begin
         check("sel_load", 32'(sel), 32'(addr_model(load_idx)));
         check("rw_load", 32'(data_RW), 32'd0);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"},    32'(out_valid), 32'd0);
      check({tag, "_done"},     32'(done),      32'd0);
      check({tag, "_busy"},     32'(busy),      32'd0);
      check({tag, "_checksum"}, checksum,       32'd0);
      check({tag, "_rw"},       32'(data_RW),   32'd1);
      check({tag, "_sel"},      32'(sel),       32'd0);
      check({tag, "_data"},     out_data,       32'd0);
      check({tag, "_idx"},      32'(out_idx),   32'd0);
   endtask

   task automatic begin_transfer();
      sb.delete();
      for (int i = 0; i < ELEMS; i++) sb.push_back('{mem[addr_model(i)], IDX_W'(i)});
      model_cs = '0;
      n_pop    = 0;
      load_idx = 0;
      n_done   = 0;
      cyc      = 0;
      done_cyc = -1;
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Runs one whole transfer; optionally stalls at one element or pulses
   // start again while an element is being offered.
   task automatic run_transfer(input int stall_at, input bit extra_start);
      bit          stalled = 1'b0;
      bit          pulsed  = 1'b0;
      logic [31:0] held_cs;
      begin_transfer();
      for (int k = 0; k < 300 && busy; k++) begin
         if (stall_at >= 0 && !stalled && out_valid && 32'(out_idx) == stall_at) begin
            out_ready = 1'b0;
            held_cs   = model_cs;
            repeat (5) begin
               tick();
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_data", out_data, mem[addr_model(stall_at)]);
               check("stall_idx", 32'(out_idx), 32'(stall_at));
               check("stall_checksum", checksum, held_cs);
            end
            out_ready = 1'b1;
            stalled   = 1'b1;
         end else if (extra_start && !pulsed && out_valid && out_idx == 4'd2) begin
            start = 1'b1;
            tick();
            start  = 1'b0;
            pulsed = 1'b1;
         end else begin
            tick();
         end
      end
      check("transfer_finished", 32'(busy), 32'd0);
      check("n_elems", 32'(n_pop), 32'(ELEMS));
      check("n_done", 32'(n_done), 32'd1);
      check("checksum_model", checksum, model_cs);
      check("sb_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < 16; k++) mem[k] = 32'd10 + 32'(k);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset = 1'b0;
      tick();

      // Plain transfer with the consumer always ready.
      run_transfer(-1, 1'b0);
      check("done_latency", 32'(done_cyc), 32'd19);
      check("checksum_126", checksum, 32'd126);
      tick();
      check("idle_checksum_hold", checksum, 32'd126);
      check("idle_rw", 32'(data_RW), 32'd1);
      check("idle_sel", 32'(sel), 32'd0);

      // Consumer stalls 5 cycles on element 4.
      run_transfer(4, 1'b0);
      check("stall_checksum_126", checksum, 32'd126);

      // Reset while element 3 is being offered, with a handshake pending.
      begin_transfer();
      for (int k = 0; k < 50 && !(out_valid && out_idx == 4'd3); k++) tick();
      check("abort_reached", 32'(out_idx), 32'd3);
      reset = 1'b1;
      tick();
      check_reset_values("abort");
      reset = 1'b0;
      repeat (3) tick();
      check("abort_no_done", 32'(n_done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      run_transfer(-1, 1'b0);
      check("restart_checksum", checksum, 32'd126);

      // start pulsed while an element is being offered is ignored.
      run_transfer(-1, 1'b1);
      check("extra_start_checksum", checksum, 32'd126);

      // Checksum wraps modulo 2^32.
      for (int k = 0; k < 16; k++) mem[k] = 32'd0;
      mem[0] = 32'hFFFF_FFFF;
      mem[1] = 32'h0000_0002;
      run_transfer(-1, 1'b0);
      check("checksum_wrap", checksum, 32'h0000_0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
